// File: rtl/voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// voice_allocator_pkg
// Shared types and helpers for the polyphonic voice allocator.
//   state_t   : allocator FSM states
//   age_max   : all-ones value of an age counter of a given width
//   idx_width : bits needed to index a voice bank (minimum 1)
// -----------------------------------------------------------------------------
package voice_allocator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2,
      RETRIG = 2'd3
   } state_t;

   function automatic int age_max(input int bits);
      return (1 << bits) - 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/voice_scan_unit.sv
// -----------------------------------------------------------------------------
// voice_scan_unit
// Walks the voice bank one index per cycle and keeps the running best
// candidates for the event being processed.
// Ports:
//   main_clk, rst_n     : clock, asynchronous active-low reset
//   i_start             : event accepted this cycle, clear index and results
//   i_en                : allocator is in SCAN
//   i_evt_note          : captured note of the event
//   i_active/i_note/i_age : state of the voice at o_idx
//   o_idx               : voice index being visited
//   o_done              : last index is being visited this cycle
//   o_match_*           : lowest-index active voice holding i_evt_note
//   o_free_*            : oldest inactive voice (lowest index on ties)
//   o_oldest_idx        : oldest active voice (lowest index on ties)
// -----------------------------------------------------------------------------
module voice_scan_unit #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_BITS  = 7,
   parameter int AGE_BITS   = 8,
   parameter int IDX_W      = 2
) (
   input  logic                 main_clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_en,
   input  logic [NOTE_BITS-1:0] i_evt_note,
   input  logic                 i_active,
   input  logic [NOTE_BITS-1:0] i_note,
   input  logic [AGE_BITS-1:0]  i_age,
   output logic [IDX_W-1:0]     o_idx,
   output logic                 o_done,
   output logic                 o_match_vld,
   output logic [IDX_W-1:0]     o_match_idx,
   output logic                 o_free_vld,
   output logic [IDX_W-1:0]     o_free_idx,
   output logic [IDX_W-1:0]     o_oldest_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   logic [IDX_W-1:0]    r_idx;
   logic                r_match_vld;
   logic [IDX_W-1:0]    r_match_idx;
   logic                r_free_vld;
   logic [IDX_W-1:0]    r_free_idx;
   logic [AGE_BITS-1:0] r_free_age;
   logic                r_old_vld;
   logic [IDX_W-1:0]    r_old_idx;
   logic [AGE_BITS-1:0] r_old_age;

   assign o_idx        = r_idx;
   assign o_done       = i_en && (r_idx == LAST_IDX);
   assign o_match_vld  = r_match_vld;
   assign o_match_idx  = r_match_idx;
   assign o_free_vld   = r_free_vld;
   assign o_free_idx   = r_free_idx;
   assign o_oldest_idx = r_old_idx;

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_match_idx <= '0;
         r_free_vld  <= 1'b0;
         r_free_idx  <= '0;
         r_free_age  <= '0;
         r_old_vld   <= 1'b0;
         r_old_idx   <= '0;
         r_old_age   <= '0;
      end else if (i_start) begin
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
         r_old_vld   <= 1'b0;
      end else if (i_en) begin
         // Hold the index on the last visit so it never wraps past the bank.
         if (!o_done) r_idx <= r_idx + 1'b1;
         // Strict '>' keeps the earlier (lower) index when ages tie.
         if (i_active) begin
            if (!r_match_vld && (i_note == i_evt_note)) begin
               r_match_vld <= 1'b1;
               r_match_idx <= r_idx;
            end
            if (!r_old_vld || (i_age > r_old_age)) begin
               r_old_vld <= 1'b1;
               r_old_idx <= r_idx;
               r_old_age <= i_age;
            end
         end else if (!r_free_vld || (i_age > r_free_age)) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
            r_free_age <= i_age;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice scheduler: accepts note-on/off events over valid/ready,
// assigns notes to voices, retriggers a voice already holding the note and,
// with VOICE_ALLOCATOR_STEAL_EN defined, reclaims the oldest voice when the
// bank is full (otherwise such a note-on is dropped).
// Ports:
//   main_clk, rst_n    : clock, asynchronous active-low reset
//   evt_valid/evt_ready: event handshake
//   evt_on, evt_note, evt_freq : event fields (captured on acceptance)
//   voice_gate         : per-voice gate
//   voice_freq         : voice i at [i*FREQ_BITS +: FREQ_BITS]
//   steal_pulse        : one cycle when an active voice is reclaimed
//   drop_pulse         : one cycle when a note-on is discarded
// -----------------------------------------------------------------------------
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES    = 4,
   parameter int FREQ_BITS     = 16,
   parameter int NOTE_BITS     = 7,
   parameter int AGE_BITS      = 8,
   parameter int RETRIG_CYCLES = 4
) (
   input  logic                            main_clk,
   input  logic                            rst_n,
   input  logic                            evt_valid,
   output logic                            evt_ready,
   input  logic                            evt_on,
   input  logic [NOTE_BITS-1:0]            evt_note,
   input  logic [FREQ_BITS-1:0]            evt_freq,
   output logic [NUM_VOICES-1:0]           voice_gate,
   output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
   output logic                            steal_pulse,
   output logic                            drop_pulse
);

   localparam int IW = idx_width(NUM_VOICES);
   localparam int RW = (RETRIG_CYCLES < 2) ? 1 : $clog2(RETRIG_CYCLES);
   localparam logic [AGE_BITS-1:0] AGE_SAT = AGE_BITS'(age_max(AGE_BITS));
   localparam logic [RW-1:0]       RT_LAST = RW'(RETRIG_CYCLES - 1);
`ifdef VOICE_ALLOCATOR_STEAL_EN
   localparam logic STEAL_EN = 1'b1;
`else
   localparam logic STEAL_EN = 1'b0;
`endif

   state_t r_state, w_next;

   logic                 r_evt_on;
   logic [NOTE_BITS-1:0] r_evt_note;
   logic [FREQ_BITS-1:0] r_evt_freq;
   logic [NOTE_BITS-1:0] r_note [NUM_VOICES];
   logic [AGE_BITS-1:0]  r_age  [NUM_VOICES];
   logic [FREQ_BITS-1:0] r_freq [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_active;
   logic [NUM_VOICES-1:0] r_gate;
   logic [IW-1:0]        r_tgt;
   logic [RW-1:0]        r_rcnt;
   logic                 r_drop;

   logic                 w_ready;
   logic                 w_accept;
   logic [IW-1:0]        w_idx;
   logic                 w_done;
   logic                 w_match_vld;
   logic [IW-1:0]        w_match_idx;
   logic                 w_free_vld;
   logic [IW-1:0]        w_free_idx;
   logic [IW-1:0]        w_oldest_idx;
   logic                 w_dropping;

   assign w_accept   = evt_valid && w_ready;
   // A full-bank note-on without stealing leaves every voice, ages included, untouched.
   assign w_dropping = r_evt_on && !w_match_vld && !w_free_vld && !STEAL_EN;

   voice_scan_unit #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_BITS  (NOTE_BITS),
      .AGE_BITS   (AGE_BITS),
      .IDX_W      (IW)
   ) u_scan (
      .main_clk     (main_clk),
      .rst_n        (rst_n),
      .i_start      (w_accept),
      .i_en         (r_state == SCAN),
      .i_evt_note   (r_evt_note),
      .i_active     (r_active[w_idx]),
      .i_note       (r_note[w_idx]),
      .i_age        (r_age[w_idx]),
      .o_idx        (w_idx),
      .o_done       (w_done),
      .o_match_vld  (w_match_vld),
      .o_match_idx  (w_match_idx),
      .o_free_vld   (w_free_vld),
      .o_free_idx   (w_free_idx),
      .o_oldest_idx (w_oldest_idx)
   );

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SCAN;
         SCAN:    if (w_done) w_next = COMMIT;
         COMMIT:  if (r_evt_on && (w_match_vld || (!w_free_vld && STEAL_EN))) w_next = RETRIG;
                  else w_next = IDLE;
         RETRIG:  if (r_rcnt == RT_LAST) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ready = (r_state == IDLE);
   end

`ifdef VOICE_ALLOCATOR_STEAL_EN
   logic r_steal;
   assign steal_pulse = r_steal;
`else
   assign steal_pulse = 1'b0;
`endif

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt_on   <= 1'b0;
         r_evt_note <= '0;
         r_evt_freq <= '0;
         r_active   <= '0;
         r_gate     <= '0;
         r_tgt      <= '0;
         r_rcnt     <= '0;
         r_drop     <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
         r_steal    <= 1'b0;
`endif
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= '0;
            r_age[i]  <= AGE_SAT;
            r_freq[i] <= '0;
         end
      end else begin
         r_drop <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
         r_steal <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_evt_on   <= evt_on;
                  r_evt_note <= evt_note;
                  r_evt_freq <= evt_freq;
               end
            end
            COMMIT: begin
               // Age everyone first; the target's zeroing below overrides its increment.
               if (!w_dropping) begin
                  for (int i = 0; i < NUM_VOICES; i++)
                     if (r_age[i] != AGE_SAT) r_age[i] <= r_age[i] + 1'b1;
               end
               r_rcnt <= '0;
               if (!r_evt_on) begin
                  if (w_match_vld) begin
                     r_gate[w_match_idx]   <= 1'b0;
                     r_active[w_match_idx] <= 1'b0;
                     r_age[w_match_idx]    <= '0;
                  end
               end else if (w_match_vld) begin
                  r_freq[w_match_idx] <= r_evt_freq;
                  r_gate[w_match_idx] <= 1'b0;
                  r_age[w_match_idx]  <= '0;
                  r_tgt               <= w_match_idx;
               end else if (w_free_vld) begin
                  r_note[w_free_idx]   <= r_evt_note;
                  r_freq[w_free_idx]   <= r_evt_freq;
                  r_gate[w_free_idx]   <= 1'b1;
                  r_active[w_free_idx] <= 1'b1;
                  r_age[w_free_idx]    <= '0;
               end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                  r_note[w_oldest_idx] <= r_evt_note;
                  r_freq[w_oldest_idx] <= r_evt_freq;
                  r_gate[w_oldest_idx] <= 1'b0;
                  r_age[w_oldest_idx]  <= '0;
                  r_tgt                <= w_oldest_idx;
                  r_steal              <= 1'b1;
`else
                  r_drop <= 1'b1;
`endif
               end
            end
            RETRIG: begin
               if (r_rcnt == RT_LAST) r_gate[r_tgt] <= 1'b1;
               else                   r_rcnt <= r_rcnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign evt_ready  = w_ready;
   assign voice_gate = r_gate;
   assign drop_pulse = r_drop;

   genvar g;
   generate
      for (g = 0; g < NUM_VOICES; g++) begin : g_freq
         assign voice_freq[g*FREQ_BITS +: FREQ_BITS] = r_freq[g];
      end
   endgenerate

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Directed testbench for voice_allocator with 4 voices and a 4-cycle retrigger.
// Expected behaviour with VOICE_ALLOCATOR_STEAL_EN follows the macro.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

   logic        main_clk = 1'b0;
   logic        rst_n;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_on;
   logic [6:0]  evt_note;
   logic [15:0] evt_freq;
   logic [3:0]  voice_gate;
   logic [63:0] voice_freq;
   logic        steal_pulse;
   logic        drop_pulse;

   int tests = 0;
   int fails = 0;

   voice_allocator #(
      .NUM_VOICES    (4),
      .FREQ_BITS     (16),
      .NOTE_BITS     (7),
      .AGE_BITS      (8),
      .RETRIG_CYCLES (4)
   ) dut (
      .main_clk    (main_clk),
      .rst_n       (rst_n),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_on      (evt_on),
      .evt_note    (evt_note),
      .evt_freq    (evt_freq),
      .voice_gate  (voice_gate),
      .voice_freq  (voice_freq),
      .steal_pulse (steal_pulse),
      .drop_pulse  (drop_pulse)
   );

   always #5 main_clk = ~main_clk;

   function automatic logic [15:0] fq(input int i);
      return voice_freq[i*16 +: 16];
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      evt_valid = 1'b0;
      evt_on    = 1'b0;
      evt_note  = '0;
      evt_freq  = '0;
      repeat (2) @(posedge main_clk);
      @(negedge main_clk);
      rst_n = 1'b1;
   endtask

   // Returns #1 after the acceptance edge (edge 0); event inputs are then scrambled.
   task automatic accept(input logic on, input logic [6:0] n, input logic [15:0] f);
      int k;
      k = 0;
      @(negedge main_clk);
      while (!evt_ready && k < 40) begin
         @(negedge main_clk);
         k++;
      end
      if (!evt_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout ready=%b expected 1", evt_ready);
      end
      evt_on = on; evt_note = n; evt_freq = f; evt_valid = 1'b1;
      @(posedge main_clk); #1;
      evt_valid = 1'b0;
      evt_on    = 1'($urandom);
      evt_note  = 7'($urandom);
      evt_freq  = 16'($urandom);
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge main_clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; evt_valid = 1'b0; evt_on = 1'b0; evt_note = '0; evt_freq = '0;
      #3;
      tests++; if (voice_gate !== 4'b0000) begin fails++; $display("FAIL rst_gate got=%b exp=0000", voice_gate); end
      tests++; if (voice_freq !== 64'd0) begin fails++; $display("FAIL rst_freq got=%h exp=0", voice_freq); end
      tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", evt_ready); end
      tests++; if ({steal_pulse, drop_pulse} !== 2'b00) begin fails++; $display("FAIL rst_pulses got=%b exp=00", {steal_pulse, drop_pulse}); end
      do_reset();
   endtask

   task automatic test_single_note();
      do_reset();
      accept(1'b1, 7'd60, 16'h1000);
      tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL t1_ready_low got=%b exp=0", evt_ready); end
      wait_edges(4);
      tests++; if (voice_gate !== 4'b0000) begin fails++; $display("FAIL t1_gate_e4 got=%b exp=0000", voice_gate); end
      tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL t1_ready_e4 got=%b exp=0", evt_ready); end
      wait_edges(1);
      tests++; if (voice_gate !== 4'b0001) begin fails++; $display("FAIL t1_gate_e5 got=%b exp=0001", voice_gate); end
      tests++; if (fq(0) !== 16'h1000) begin fails++; $display("FAIL t1_freq0 got=%h exp=1000", fq(0)); end
      tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL t1_ready_back got=%b exp=1", evt_ready); end
   endtask

   task automatic load_four();
      accept(1'b1, 7'd60, 16'h1000);
      accept(1'b1, 7'd62, 16'h1100);
      accept(1'b1, 7'd64, 16'h1200);
      accept(1'b1, 7'd67, 16'h1300);
      wait_edges(12);
   endtask

   task automatic test_alloc_release();
      do_reset();
      load_four();
      tests++; if (voice_gate !== 4'b1111) begin fails++; $display("FAIL t2_gates_full got=%b exp=1111", voice_gate); end
      tests++; if (voice_freq !== 64'h1300_1200_1100_1000) begin fails++; $display("FAIL t2_freqs got=%h exp=1300120011001000", voice_freq); end
      accept(1'b0, 7'd62, 16'hDEAD);
      wait_edges(12);
      tests++; if (voice_gate !== 4'b1101) begin fails++; $display("FAIL t2_gates_off got=%b exp=1101", voice_gate); end
      tests++; if (voice_freq !== 64'h1300_1200_1100_1000) begin fails++; $display("FAIL t2_freqs_kept got=%h exp=1300120011001000", voice_freq); end
   endtask

   task automatic test_full_bank();
      do_reset();
      load_four();
      accept(1'b1, 7'd72, 16'h2000);
      wait_edges(4);
      tests++; if (voice_gate !== 4'b1111) begin fails++; $display("FAIL t3_gate_e4 got=%b exp=1111", voice_gate); end
      wait_edges(1);
`ifdef VOICE_ALLOCATOR_STEAL_EN
      tests++; if (voice_gate !== 4'b1110) begin fails++; $display("FAIL t3_gate_e5 got=%b exp=1110", voice_gate); end
      tests++; if (steal_pulse !== 1'b1) begin fails++; $display("FAIL t3_steal_e5 got=%b exp=1", steal_pulse); end
      tests++; if (fq(0) !== 16'h2000) begin fails++; $display("FAIL t3_freq0 got=%h exp=2000", fq(0)); end
      wait_edges(1);
      tests++; if (steal_pulse !== 1'b0) begin fails++; $display("FAIL t3_steal_e6 got=%b exp=0", steal_pulse); end
      wait_edges(2);
      tests++; if (voice_gate !== 4'b1110) begin fails++; $display("FAIL t3_gate_e8 got=%b exp=1110", voice_gate); end
      wait_edges(1);
      tests++; if (voice_gate !== 4'b1111) begin fails++; $display("FAIL t3_gate_e9 got=%b exp=1111", voice_gate); end
      accept(1'b0, 7'd72, 16'h0);
`else
      tests++; if (drop_pulse !== 1'b1) begin fails++; $display("FAIL t3_drop_e5 got=%b exp=1", drop_pulse); end
      tests++; if (steal_pulse !== 1'b0) begin fails++; $display("FAIL t3_steal_tied got=%b exp=0", steal_pulse); end
      tests++; if (voice_gate !== 4'b1111) begin fails++; $display("FAIL t3_gate_e5 got=%b exp=1111", voice_gate); end
      tests++; if (fq(0) !== 16'h1000) begin fails++; $display("FAIL t3_freq0 got=%h exp=1000", fq(0)); end
      wait_edges(1);
      tests++; if (drop_pulse !== 1'b0) begin fails++; $display("FAIL t3_drop_e6 got=%b exp=0", drop_pulse); end
      accept(1'b0, 7'd60, 16'h0);
`endif
      wait_edges(12);
      tests++; if (voice_gate !== 4'b1110) begin fails++; $display("FAIL t3_release_v0 got=%b exp=1110", voice_gate); end
   endtask

   task automatic test_retrigger();
      do_reset();
      accept(1'b1, 7'd50, 16'h0500);
      accept(1'b1, 7'd52, 16'h0520);
      accept(1'b1, 7'd60, 16'h0600);
      wait_edges(12);
      accept(1'b1, 7'd60, 16'h0777);
      wait_edges(4);
      tests++; if (voice_gate !== 4'b0111) begin fails++; $display("FAIL t4_gate_e4 got=%b exp=0111", voice_gate); end
      for (int e = 5; e <= 8; e++) begin
         wait_edges(1);
         tests++; if (voice_gate !== 4'b0011) begin fails++; $display("FAIL t4_gate_low e=%0d got=%b exp=0011", e, voice_gate); end
      end
      tests++; if (voice_freq !== 64'h0000_0777_0520_0500) begin fails++; $display("FAIL t4_freqs got=%h exp=0000077705200500", voice_freq); end
      tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL t4_ready_e8 got=%b exp=0", evt_ready); end
      wait_edges(1);
      tests++; if (voice_gate !== 4'b0111) begin fails++; $display("FAIL t4_gate_e9 got=%b exp=0111", voice_gate); end
      tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL t4_ready_e9 got=%b exp=1", evt_ready); end
   endtask

   task automatic test_unheld_off();
      do_reset();
      accept(1'b1, 7'd60, 16'h1000);
      accept(1'b1, 7'd62, 16'h1100);
      wait_edges(12);
      accept(1'b0, 7'd50, 16'h0);
      for (int e = 1; e <= 5; e++) begin
         wait_edges(1);
         tests++; if (voice_gate !== 4'b0011 || {steal_pulse, drop_pulse} !== 2'b00)
            begin fails++; $display("FAIL t5_quiet e=%0d gate=%b pulses=%b exp 0011/00", e, voice_gate, {steal_pulse, drop_pulse}); end
         if (e == 4) begin
            tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL t5_ready_e4 got=%b exp=0", evt_ready); end
         end
      end
      tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL t5_ready_e5 got=%b exp=1", evt_ready); end
      tests++; if (voice_freq !== 64'h0000_0000_1100_1000) begin fails++; $display("FAIL t5_freqs got=%h exp=0000000011001000", voice_freq); end
   endtask

   task automatic test_reset_mid_retrig();
      do_reset();
      accept(1'b1, 7'd60, 16'h1000);
      accept(1'b1, 7'd60, 16'h1234);
      wait_edges(6);
      tests++; if (voice_gate !== 4'b0000) begin fails++; $display("FAIL t6_in_retrig got=%b exp=0000", voice_gate); end
      rst_n = 1'b0;
      #1;
      tests++; if (voice_gate !== 4'b0000 || voice_freq !== 64'd0)
         begin fails++; $display("FAIL t6_async_clear gate=%b freq=%h exp 0000/0", voice_gate, voice_freq); end
      @(negedge main_clk);
      rst_n = 1'b1;
      #1;
      tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL t6_ready got=%b exp=1", evt_ready); end
      accept(1'b1, 7'd64, 16'h4444);
      wait_edges(5);
      tests++; if (voice_gate !== 4'b0001 || fq(0) !== 16'h4444)
         begin fails++; $display("FAIL t6_after gate=%b f0=%h exp 0001/4444", voice_gate, fq(0)); end
   endtask

   initial begin
      test_reset();
      test_single_note();
      test_alloc_release();
      test_full_bank();
      test_retrigger();
      test_unheld_off();
      test_reset_mid_retrig();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
